// File: rtl/mux_scan_sampler_if.sv
// rtl/mux_scan_sampler_if.sv - word handshake bundle between the mux scan sampler and its consumer
// Purpose: carries the completed 4-bit scan word with a valid/ready handshake.
// Signals:
//   word        4  scanned word, word[i] = mux sample taken at address i
//   word_valid  1  word is complete and held stable
//   word_ready  1  consumer accepts word this cycle
// Modports: master = sampler side (drives word/word_valid), slave = consumer side.
interface mux_scan_sampler_if;
  logic [3:0] word;
  logic       word_valid;
  logic       word_ready;

  modport master (output word, output word_valid, input word_ready);
  modport slave  (input word, input word_valid, output word_ready);
endinterface

// File: rtl/mux_scan_sampler.sv
// rtl/mux_scan_sampler.sv - steps a 4:1 mux select through 0..3 and samples its output into a word
// Purpose: on start, holds each mux address for SETTLE_CYCLES clocks so the mux
//   gate chain resolves, samples mux_out at the end of each hold, and presents the
//   four samples as one word on a valid/ready handshake.
// Parameters:
//   SETTLE_CYCLES  clocks each address is held before its sample (1..255)
// Ports:
//   clk       in   rising-edge clock
//   reset     in   synchronous active-high reset
//   start     in   scan request (honoured in IDLE, or in VALID when the word is accepted)
//   mux_out   in   out pin of the 4:1 mux
//   address0  out  mux select bit 0
//   address1  out  mux select bit 1
//   busy      out  high whenever the sequencer is not idle
//   wbus      if   word / word_valid / word_ready handshake (master side)
module mux_scan_sampler #(
  parameter int SETTLE_CYCLES = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                mux_out,
  output logic                address0,
  output logic                address1,
  output logic                busy,
  mux_scan_sampler_if.master  wbus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    VALID  = 2'd2
  } state_t;

  localparam logic [7:0] RELOAD = 8'(SETTLE_CYCLES - 1);

  state_t     state, state_n;
  logic [7:0] cnt, cnt_n;
  logic [1:0] addr, addr_n;
  logic [3:0] capture, capture_n;
  logic [3:0] word_q, word_n;
  logic       valid_q, busy_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= 8'd0;
      addr    <= 2'd0;
      capture <= 4'd0;
      word_q  <= 4'd0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      addr    <= addr_n;
      capture <= capture_n;
      word_q  <= word_n;
      // Flags are registered from the next state so they line up with it.
      valid_q <= (state_n == VALID);
      busy_q  <= (state_n != IDLE);
    end
  end

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    addr_n    = addr;
    capture_n = capture;
    word_n    = word_q;
    case (state)
      IDLE: begin
        if (start) begin
          state_n = SETTLE;
          addr_n  = 2'd0;
          cnt_n   = RELOAD;
        end
      end
      SETTLE: begin
        if (cnt != 8'd0) begin
          cnt_n = cnt - 8'd1;
        end else begin
          capture_n[addr] = mux_out;
          if (addr != 2'd3) begin
            addr_n = addr + 2'd1;
            cnt_n  = RELOAD;
          end else begin
            // Word is published only here, with the final sample folded in,
            // so a partial scan never reaches the output.
            word_n  = capture_n;
            addr_n  = 2'd0;
            state_n = VALID;
          end
        end
      end
      VALID: begin
        if (wbus.word_ready) begin
          if (start) begin
            // Back-to-back scan without an idle cycle.
            state_n = SETTLE;
            addr_n  = 2'd0;
            cnt_n   = RELOAD;
          end else begin
            state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign address0        = addr[0];
  assign address1        = addr[1];
  assign busy            = busy_q;
  assign wbus.word       = word_q;
  assign wbus.word_valid = valid_q;

endmodule

// File: tb/tb_mux_scan_sampler.sv
// tb/tb_mux_scan_sampler.sv - directed, table-driven bench for mux_scan_sampler
// Purpose: drives a behavioural 4:1 mux (S=4 instance) and a gate-style mux
//   (S=1 instance) in the loop and checks address stepping, sample timing, the
//   word handshake, start filtering and mid-scan reset.
// Ports: none (top-level bench).
module tb_mux_scan_sampler;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       start2 = 1'b0;
  logic [3:0] in_bits = 4'd0;
  logic [3:0] in2 = 4'd0;
  logic       a0, a1, b0, b1, busy, busy2;
  logic       mux_out, mux2_out;

  mux_scan_sampler_if bus1();
  mux_scan_sampler_if bus2();

  // Behavioural mux for the S=4 instance.
  assign mux_out = in_bits[{a1, a0}];

  // Gate-style mux (NOT -> AND -> OR tree) for the S=1 instance.
  logic nb0, nb1, t0, t1, t2, t3;
  assign nb0 = ~b0;
  assign nb1 = ~b1;
  assign t0 = in2[0] & nb1 & nb0;
  assign t1 = in2[1] & nb1 & b0;
  assign t2 = in2[2] & b1 & nb0;
  assign t3 = in2[3] & b1 & b0;
  assign mux2_out = (t0 | t1) | (t2 | t3);

  mux_scan_sampler #(.SETTLE_CYCLES(4)) dut (
    .clk(clk), .reset(reset), .start(start), .mux_out(mux_out),
    .address0(a0), .address1(a1), .busy(busy), .wbus(bus1)
  );

  mux_scan_sampler #(.SETTLE_CYCLES(1)) dut2 (
    .clk(clk), .reset(reset), .start(start2), .mux_out(mux2_out),
    .address0(b0), .address1(b1), .busy(busy2), .wbus(bus2)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, actual, expected);
    end
  endtask

  typedef struct {
    logic [3:0] in_bits;
    logic [3:0] exp_word;
  } vec_t;

  vec_t vecs[6];

  // Called at the negedge just after the start edge E0; returns at the negedge
  // after E0+16 with the word checked. A stray start pulse mid-scan must be ignored.
  task automatic scan_body(input logic [3:0] exp_word);
    for (int j = 0; j < 16; j++) begin
      check("scan_addr", int'({a1, a0}), j / 4);
      check("scan_valid_low", int'(bus1.word_valid), 0);
      check("scan_busy", int'(busy), 1);
      start = (j == 7);
      @(negedge clk);
    end
    start = 1'b0;
    check("done_valid", int'(bus1.word_valid), 1);
    check("done_word", int'(bus1.word), int'(exp_word));
    check("done_addr", int'({a1, a0}), 0);
    check("done_busy", int'(busy), 1);
  endtask

  task automatic run_scan(input logic [3:0] inb, input logic [3:0] exp_word);
    in_bits = inb;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    scan_body(exp_word);
  endtask

  task automatic accept;
    bus1.word_ready = 1'b1;
    @(negedge clk);
    bus1.word_ready = 1'b0;
    check("accept_valid", int'(bus1.word_valid), 0);
    check("accept_busy", int'(busy), 0);
  endtask

  initial begin
    vecs[0] = '{4'b1101, 4'b1101};  // in0..in3 = 1,0,1,1
    vecs[1] = '{4'b0110, 4'b0110};  // in0..in3 = 0,1,1,0
    vecs[2] = '{4'b0000, 4'b0000};
    vecs[3] = '{4'b1111, 4'b1111};
    vecs[4] = '{4'b1000, 4'b1000};
    vecs[5] = '{4'b0001, 4'b0001};

    bus1.word_ready = 1'b0;
    bus2.word_ready = 1'b0;

    // 1. reset
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("rst_addr", int'({a1, a0}), 0);
    check("rst_word", int'(bus1.word), 0);
    check("rst_valid", int'(bus1.word_valid), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_busy2", int'(busy2), 0);
    @(negedge clk);

    // 2. table of full scans, each accepted
    for (int v = 0; v < 6; v++) begin
      run_scan(vecs[v].in_bits, vecs[v].exp_word);
      accept();
      check("idle_word_kept", int'(bus1.word), int'(vecs[v].exp_word));
      @(negedge clk);
    end

    // 3. hold in VALID with ready low; start pulses and input changes are ignored
    run_scan(4'b1101, 4'b1101);
    in_bits = 4'b0000;
    for (int k = 0; k < 10; k++) begin
      start = (k == 3) || (k == 4);
      @(negedge clk);
      check("hold_valid", int'(bus1.word_valid), 1);
      check("hold_word", int'(bus1.word), 4'b1101);
      check("hold_busy", int'(busy), 1);
      check("hold_addr", int'({a1, a0}), 0);
    end
    start = 1'b0;

    // 4. accept with start high: immediate rescan
    in_bits = 4'b0110;
    bus1.word_ready = 1'b1;
    start = 1'b1;
    @(negedge clk);
    bus1.word_ready = 1'b0;
    start = 1'b0;
    check("b2b_word_held", int'(bus1.word), 4'b1101);
    scan_body(4'b0110);
    accept();
    @(negedge clk);

    // 5. reset at E0+6 aborts the scan
    in_bits = 4'b1111;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int j = 0; j < 5; j++) @(negedge clk);
    check("pre_abort_addr", int'({a1, a0}), 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_addr", int'({a1, a0}), 0);
    check("abort_word", int'(bus1.word), 0);
    check("abort_valid", int'(bus1.word_valid), 0);
    check("abort_busy", int'(busy), 0);
    for (int j = 0; j < 20; j++) begin
      @(negedge clk);
      check("abort_no_valid", int'(bus1.word_valid), 0);
      check("abort_idle", int'(busy), 0);
    end

    // 6. S=1 with the gate-style mux
    for (int v = 0; v < 2; v++) begin
      in2 = (v == 0) ? 4'b1011 : 4'b0100;
      start2 = 1'b1;
      @(negedge clk);
      start2 = 1'b0;
      for (int j = 0; j < 4; j++) begin
        check("s1_addr", int'({b1, b0}), j);
        check("s1_valid_low", int'(bus2.word_valid), 0);
        @(negedge clk);
      end
      check("s1_valid", int'(bus2.word_valid), 1);
      check("s1_word", int'(bus2.word), int'(in2));
      bus2.word_ready = 1'b1;
      @(negedge clk);
      bus2.word_ready = 1'b0;
      check("s1_accept", int'(bus2.word_valid), 0);
      check("s1_idle", int'(busy2), 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
